vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator; first stage of the VGA video path.
//  Produces the running column/row coordinates consumed by the pattern/pixel
//  stages, plus hsync, vsync, visible and line/frame strobes.
//  Uses one system clock with an enable that marks pixel ticks.
//  Its timing is fully parameterised, so any VGA mode can be generated.
// PARAMETERS
//  H_VISIBLE   640  active pixels per line
//  H_FRONT     16   horizontal front porch, in pixels
//  H_SYNC      96   hsync pulse width, in pixels
//  H_BACK      48   horizontal back porch, in pixels
//  V_VISIBLE   480  active lines per frame
//  V_FRONT     10   vertical front porch, in lines
//  V_SYNC      2    vsync pulse width, in lines
//  V_BACK      33   vertical back porch, in lines
//  H_SYNC_POL  0    hsync active level (0 = active-low)
//  V_SYNC_POL  0    vsync active level (0 = active-low)
//  Derived localparams:
//   H_WHOLE     = H_VISIBLE+H_FRONT+H_SYNC+H_BACK
//   V_WHOLE     = V_VISIBLE+V_FRONT+V_SYNC+V_BACK
//   COLUMN_BITS = $clog2(H_WHOLE)
//   ROW_BITS    = $clog2(V_WHOLE)
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            async active-low reset
//  enable       in   1            pixel tick; counters advance only when high
//  column       out  COLUMN_BITS  current column, 0..H_WHOLE-1
//  row          out  ROW_BITS     current row, 0..V_WHOLE-1
//  hsync        out  1            horizontal sync, polarity set by H_SYNC_POL
//  vsync        out  1            vertical sync, polarity set by V_SYNC_POL
//  visible      out  1            column<H_VISIBLE && row<V_VISIBLE
//  line_start   out  1            1-clk pulse: column just wrapped to 0
//  frame_start  out  1            1-clk pulse: (column,row) just wrapped to (0,0)
//  frame_count  out  16           present only with VGA_SYNC_FRAME_COUNT_EN
// BEHAVIOUR
//  Clock and reset:
//   - Clock and reset are the single clk and the async active-low reset_n above.
//  Reset values (applied asynchronously while reset_n=0):
//   - column=0, row=0, visible=1
//   - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (both deasserted)
//   - line_start=0, frame_start=0, frame_count=0
//  Counting (on a clk edge with enable=1):
//   - column <= column+1, or 0 when column==H_WHOLE-1.
//   - On that column wrap: row <= row+1, or 0 when row==V_WHOLE-1.
//  Output registering and alignment:
//   - All outputs are registered.
//   - hsync, vsync and visible are decoded from the next-state counters, so
//     they align with the column/row shown in the same cycle. Latency 0 vs
//     the coordinates.
//  Sync decode:
//   - hsync is asserted iff H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC.
//   - vsync is asserted iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC.
//   - vsync depends on row only and changes together with the column wrap.
//  Strobes:
//   - line_start=1 for exactly one clk when column steps H_WHOLE-1 -> 0.
//   - frame_start=1 for exactly one clk when the counters step to (0,0).
//   - Neither strobe is asserted by leaving reset.
//  enable=0:
//   - All counters and levels hold.
//   - Strobes are 0 from the next edge onward.
//   - enable may toggle every cycle.
//  Reset mid-frame: outputs return to their reset values immediately; no
//   partial-line state is retained.
//  Arithmetic:
//   - Counters never hold values >= H_WHOLE/V_WHOLE.
//   - Comparisons are unsigned at full counter width.
// CONFIGURATION
//  VGA_SYNC_FRAME_COUNT_EN defined:
//   - Adds port frame_count[15:0], reset 0.
//   - Increments in the same cycle frame_start is set.
//   - Wraps 16'hFFFF -> 0.
//  VGA_SYNC_FRAME_COUNT_EN undefined:
//   - Port and counter are absent.
//   - All other behaviour is identical.
// TESTING  (default 640x480 timing: H_WHOLE=800, V_WHOLE=525; enable=1 unless noted)
//  1. Release reset_n, run 800 clks
//     -> column 0..799 then 0; line_start high only at the wrap;
//        row 0 -> 1; visible low for columns 640..799.
//  2. Scan a full line
//     -> hsync=0 exactly for columns 656..751 (96 clks), 1 elsewhere.
//  3. Run 420000 clks (one frame)
//     -> vsync=0 exactly for rows 490..491;
//        frame_start a single pulse at (0,0); no strobe right after reset.
//  4. Toggle enable 1,0,1,0 from column 798
//     -> column 798,799(hold),0(hold);
//        line_start lasts 1 clk despite enable=0 next cycle.
//  5. Assert reset_n=0 asynchronously at row 300, column 400
//     -> column=0, row=0, hsync=vsync=1, visible=1 before next clk edge.
//  6. With VGA_SYNC_FRAME_COUNT_EN, run 3 frames
//     -> frame_count 0,1,2,3 stepping with frame_start;
//        build without the macro compiles and passes 1-5.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Raster timing generator: column/row counters, syncs, visible, strobes.
// Optional 16-bit frame counter enabled by VGA_SYNC_FRAME_COUNT_EN.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0,
  localparam int unsigned H_WHOLE =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_WHOLE =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int COLUMN_BITS = $clog2(H_WHOLE),
  localparam int ROW_BITS    = $clog2(V_WHOLE)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic [COLUMN_BITS-1:0] column,
  output logic [ROW_BITS-1:0]    row,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   visible,
  output logic                   line_start,
`ifdef VGA_SYNC_FRAME_COUNT_EN
  output logic                   frame_start,
  output logic [15:0]            frame_count
`else
  output logic                   frame_start
`endif
);

  localparam int unsigned H_SS = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SE = H_SS + H_SYNC;
  localparam int unsigned V_SS = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SE = V_SS + V_SYNC;

  localparam logic [COLUMN_BITS-1:0] H_LAST =
    COLUMN_BITS'(H_WHOLE - 1);
  localparam logic [ROW_BITS-1:0] V_LAST =
    ROW_BITS'(V_WHOLE - 1);

  logic                   col_last;
  logic                   row_last;
  logic [COLUMN_BITS-1:0] col_nxt;
  logic [ROW_BITS-1:0]    row_nxt;
  logic                   hs_on;
  logic                   vs_on;
  logic                   vis_nxt;

  always_comb begin
    col_last = (column == H_LAST);
    row_last = (row == V_LAST);
    col_nxt  = col_last ? '0 : column + COLUMN_BITS'(1);
    row_nxt  = row;
    if (col_last)
      row_nxt = row_last ? '0 : row + ROW_BITS'(1);
    // decode on next-state counters so levels line up with coordinates
    hs_on   = (32'(col_nxt) >= H_SS) && (32'(col_nxt) < H_SE);
    vs_on   = (32'(row_nxt) >= V_SS) && (32'(row_nxt) < V_SE);
    vis_nxt = (32'(col_nxt) < H_VISIBLE) &&
              (32'(row_nxt) < V_VISIBLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      column      <= '0;
      row         <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      visible     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      column      <= col_nxt;
      row         <= row_nxt;
      hsync       <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
      visible     <= vis_nxt;
      line_start  <= col_last;
      frame_start <= col_last && row_last;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_SYNC_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      frame_count <= '0;
    else if (enable && col_last && row_last)
      frame_count <= frame_count + 16'd1;
  end
`endif

endmodule
